// File: rtl/matrix_reader_pkg.sv
// matrix_reader shared constants, state encoding and helpers.
// Imported by the reader, its stream interface and its index counter.
package matrix_reader_pkg;

  localparam int MAX_DIM    = 5;
  localparam int ELEM_WIDTH = 8;
  localparam int DIM_BITS   = 3;
  localparam int DIM_W      = 4;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_CHECK,
    RD_ISSUE,
    RD_WAIT,
    RD_OUT,
    RD_FIN
  } rd_state_e;

  function automatic logic dim_ok(
    input logic [DIM_W-1:0] d
  );
    return (d != '0) &&
           (d <= DIM_W'(MAX_DIM));
  endfunction

endpackage

// File: rtl/matrix_reader_if.sv
// matrix_reader element stream: valid/ready with coordinates.
// master drives the element, slave returns ready.
interface matrix_reader_if
  import matrix_reader_pkg::*;
();

  logic                  valid;
  logic                  ready;
  logic [ELEM_WIDTH-1:0] elem;
  logic [DIM_BITS-1:0]   row;
  logic [DIM_BITS-1:0]   col;
  logic                  eol;
  logic                  last;
  logic                  miss;

  modport master (
    output valid, elem, row, col,
    output eol, last, miss,
    input  ready
  );

  modport slave (
    input  valid, elem, row, col,
    input  eol, last, miss,
    output ready
  );

endinterface

// File: rtl/matrix_reader_index_counter.sv
// Row-major row/col walker with clear and advance.
// Dims are compared against zero-extended indices.
module matrix_reader_index_counter
  import matrix_reader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                advance,
  input  logic [DIM_W-1:0]    m,
  input  logic [DIM_W-1:0]    n,
  output logic [DIM_BITS-1:0] row,
  output logic [DIM_BITS-1:0] col,
  output logic                eol,
  output logic                last
);

  assign eol  = (DIM_W'(col) == n - DIM_W'(1));
  assign last = eol &&
                (DIM_W'(row) == m - DIM_W'(1));

  // step col, wrapping into the next row at eol
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (eol) begin
        col <= '0;
        row <= row + DIM_BITS'(1);
      end else begin
        col <= col + DIM_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_reader.sv
// matrix_reader: walks a stored matrix row-major and streams it.
// Owns the storage rd_en edge protocol (strobe, gap, 1-cycle data).
module matrix_reader
  import matrix_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIM_W-1:0]      req_m,
  input  logic [DIM_W-1:0]      req_n,
  input  logic                  req_slot,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DIM_W-1:0]      query_m,
  output logic [DIM_W-1:0]      query_n,
  input  logic                  query_slot0_valid,
  input  logic                  query_slot1_valid,
  output logic                  rd_en,
  output logic [DIM_W-1:0]      rd_m,
  output logic [DIM_W-1:0]      rd_n,
  output logic                  rd_slot_idx,
  output logic [DIM_BITS-1:0]   rd_row_idx,
  output logic [DIM_BITS-1:0]   rd_col_idx,
  input  logic [ELEM_WIDTH-1:0] rd_elem,
  input  logic                  rd_elem_valid,
  matrix_reader_if.master       out
);

  rd_state_e             state;
  rd_state_e             next;
  logic [DIM_W-1:0]      m_q;
  logic [DIM_W-1:0]      n_q;
  logic                  slot_q;
  logic                  miss_q;
  logic [ELEM_WIDTH-1:0] elem_q;
  logic                  elem_miss_q;
  logic                  done_q;
  logic                  err_q;
  logic [DIM_BITS-1:0]   row;
  logic [DIM_BITS-1:0]   col;
  logic                  eol;
  logic                  last;
  logic                  hs;
  logic                  req_ok;
  logic                  slot_ok;
  logic                  go;
  logic                  adv;

  assign hs      = (state == RD_OUT) && out.ready;
  assign req_ok  = dim_ok(req_m) && dim_ok(req_n);
  assign slot_ok = slot_q ? query_slot1_valid
                          : query_slot0_valid;
  assign go      = (state == RD_IDLE) && start &&
                   !abort && req_ok;
  assign adv     = hs && !last && !abort;

  matrix_reader_index_counter u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (go),
    .advance (adv),
    .m       (m_q),
    .n       (n_q),
    .row     (row),
    .col     (col),
    .eol     (eol),
    .last    (last)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= RD_IDLE;
    else     state <= next;
  end

  // next state; abort overrides every transition
  always_comb begin
    next = state;
    unique case (state)
      RD_IDLE:  if (go) next = RD_CHECK;
      RD_CHECK: next = slot_ok ? RD_ISSUE : RD_IDLE;
      RD_ISSUE: next = RD_WAIT;
      RD_WAIT:  next = RD_OUT;
      RD_OUT: begin
        if (hs) next = last ? RD_FIN : RD_ISSUE;
      end
      RD_FIN:   next = RD_IDLE;
      default:  next = RD_IDLE;
    endcase
    if (abort) next = RD_IDLE;
  end

  // request latch, element capture, done/err pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q         <= '0;
      n_q         <= '0;
      slot_q      <= 1'b0;
      miss_q      <= 1'b0;
      elem_q      <= '0;
      elem_miss_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (!abort) begin
        unique case (state)
          RD_IDLE: begin
            if (start && !req_ok) begin
              err_q <= 1'b1;
            end else if (start) begin
              m_q    <= req_m;
              n_q    <= req_n;
              slot_q <= req_slot;
              miss_q <= 1'b0;
            end
          end
          RD_CHECK: begin
            if (!slot_ok) err_q <= 1'b1;
          end
          RD_WAIT: begin
            if (rd_elem_valid) begin
              elem_q      <= rd_elem;
              elem_miss_q <= 1'b0;
            end else begin
              elem_q      <= '0;
              elem_miss_q <= 1'b1;
              miss_q      <= 1'b1;
            end
          end
          RD_OUT: begin
            if (hs && last) begin
              done_q <= 1'b1;
              err_q  <= miss_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy        = (state != RD_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign query_m     = m_q;
  assign query_n     = n_q;
  assign rd_en       = (state == RD_ISSUE);
  assign rd_m        = m_q;
  assign rd_n        = n_q;
  assign rd_slot_idx = slot_q;
  assign rd_row_idx  = row;
  assign rd_col_idx  = col;

  assign out.valid = (state == RD_OUT);
  assign out.elem  = elem_q;
  assign out.row   = row;
  assign out.col   = col;
  assign out.eol   = eol;
  assign out.last  = last;
  assign out.miss  = elem_miss_q;

endmodule
